// File: rtl/operand_fetch_stage_if.sv
// Decode-side and execute-side handshake bundle of the operand fetch stage.
// The slave modport is the stage's view; master is the view of the surrounding pipeline.
interface operand_fetch_stage_if #(
  parameter int TAG_W = 32
);
  logic             dec_valid_in;
  logic             dec_ready_out;
  logic [4:0]       dec_rs1_idx_in;
  logic [4:0]       dec_rs2_idx_in;
  logic [4:0]       dec_rd_idx_in;
  logic             dec_rd_wr_in;
  logic [TAG_W-1:0] dec_tag_in;

  logic             ex_valid_out;
  logic             ex_ready_in;
  logic [31:0]      ex_rs1_data_out;
  logic [31:0]      ex_rs2_data_out;
  logic [4:0]       ex_rd_idx_out;
  logic             ex_rd_wr_out;
  logic [TAG_W-1:0] ex_tag_out;

  modport slave (
    input  dec_valid_in, dec_rs1_idx_in, dec_rs2_idx_in, dec_rd_idx_in, dec_rd_wr_in, dec_tag_in,
    output dec_ready_out,
    output ex_valid_out, ex_rs1_data_out, ex_rs2_data_out, ex_rd_idx_out, ex_rd_wr_out, ex_tag_out,
    input  ex_ready_in
  );

  modport master (
    output dec_valid_in, dec_rs1_idx_in, dec_rs2_idx_in, dec_rd_idx_in, dec_rd_wr_in, dec_tag_in,
    input  dec_ready_out,
    input  ex_valid_out, ex_rs1_data_out, ex_rs2_data_out, ex_rd_idx_out, ex_rd_wr_out, ex_tag_out,
    output ex_ready_in
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode->execute operand fetch: regfile read with writeback bypass, per-register
// in-flight write counters, RAW/WAW stall, and a single registered output slot.
module operand_fetch_stage #(
  parameter int TAG_W = 32,
  parameter int CNT_W = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_low_in,
  operand_fetch_stage_if.slave  bus,
  output logic [4:0]            src1_idx_out,
  input  logic [31:0]           src1_data_in,
  output logic [4:0]            src2_idx_out,
  input  logic [31:0]           src2_data_in,
  input  logic                  wb_en_in,
  input  logic [4:0]            wb_idx_in,
  input  logic [31:0]           wb_data_in,
  input  logic                  rel_en_in,
  input  logic [4:0]            rel_idx_in,
  input  logic                  flush_in
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      underflow;

  logic             ex_valid_q;
  logic [31:0]      ex_rs1_q;
  logic [31:0]      ex_rs2_q;
  logic [4:0]       ex_rd_idx_q;
  logic             ex_rd_wr_q;
  logic [TAG_W-1:0] ex_tag_q;

  logic [4:0]  rs1, rs2, rd;
  logic        eff_wr;
  logic        wb_rs1, wb_rs2;
  logic        hazard;
  logic        dec_ready;
  logic        capture;
  logic        flush_rel;
  logic [31:0] opnd1, opnd2;

  // Next counter value from one increment and up to three decrements;
  // MSB of the result flags an illegal decrement below zero.
  function automatic logic [CNT_W:0] cnt_step(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec_wb,
    input logic             dec_rel,
    input logic             dec_flush
  );
    logic [CNT_W+1:0] up;
    logic [CNT_W+1:0] down;
    up   = {2'b00, cur} + (CNT_W+2)'(inc);
    down = (CNT_W+2)'(dec_wb) + (CNT_W+2)'(dec_rel) + (CNT_W+2)'(dec_flush);
    if (down > up) return {1'b1, {CNT_W{1'b0}}};
    return {1'b0, CNT_W'(up - down)};
  endfunction

  assign rs1          = bus.dec_rs1_idx_in;
  assign rs2          = bus.dec_rs2_idx_in;
  assign rd           = bus.dec_rd_idx_in;
  assign src1_idx_out = rs1;
  assign src2_idx_out = rs2;

  // NOTE: every always_comb output gets a value on every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    eff_wr    = bus.dec_rd_wr_in && (rd != 5'd0);
    wb_rs1    = wb_en_in && (wb_idx_in == rs1) && (rs1 != 5'd0);
    wb_rs2    = wb_en_in && (wb_idx_in == rs2) && (rs2 != 5'd0);
    hazard    = 1'b0;
    if ((rs1 != 5'd0) && (cnt_q[rs1] > CNT_W'(wb_rs1))) hazard = 1'b1;
    if ((rs2 != 5'd0) && (cnt_q[rs2] > CNT_W'(wb_rs2))) hazard = 1'b1;
    if (eff_wr && (cnt_q[rd] == CNT_MAX))               hazard = 1'b1;
    dec_ready = !flush_in && !hazard && (!ex_valid_q || bus.ex_ready_in);
    capture   = bus.dec_valid_in && dec_ready;
    // A flushed slot that is handed off in the same cycle keeps its write in flight.
    flush_rel = flush_in && ex_valid_q && !bus.ex_ready_in && ex_rd_wr_q;
    opnd1     = (rs1 == 5'd0) ? 32'd0 : (wb_rs1 ? wb_data_in : src1_data_in);
    opnd2     = (rs2 == 5'd0) ? 32'd0 : (wb_rs2 ? wb_data_in : src2_data_in);
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      {underflow[r], cnt_d[r]} = cnt_step(
        cnt_q[r],
        capture && eff_wr && (rd == 5'(r)),
        wb_en_in && (wb_idx_in == 5'(r)) && (r != 0),
        rel_en_in && (rel_idx_in == 5'(r)) && (r != 0),
        flush_rel && (ex_rd_idx_q == 5'(r)) && (r != 0));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_low_in) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_idx_q <= '0;
      ex_rd_wr_q  <= 1'b0;
      ex_tag_q    <= '0;
      // NOTE: the counter array is reset (not left to initialise) because in-flight state must never survive reset.
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      if (capture) begin
        ex_valid_q  <= 1'b1;
        ex_rs1_q    <= opnd1;
        ex_rs2_q    <= opnd2;
        ex_rd_idx_q <= rd;
        ex_rd_wr_q  <= bus.dec_rd_wr_in;
        ex_tag_q    <= bus.dec_tag_in;
      end else if (flush_in || bus.ex_ready_in) begin
        ex_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.dec_ready_out   = dec_ready;
  assign bus.ex_valid_out    = ex_valid_q;
  assign bus.ex_rs1_data_out = ex_rs1_q;
  assign bus.ex_rs2_data_out = ex_rs2_q;
  assign bus.ex_rd_idx_out   = ex_rd_idx_q;
  assign bus.ex_rd_wr_out    = ex_rd_wr_q;
  assign bus.ex_tag_out      = ex_tag_q;

  no_cnt_underflow: assert property (@(posedge clk_in) disable iff (!rst_low_in) underflow == 32'd0);

endmodule
